combat_resolver: RTL and testbench
==================================

# combat_resolver

Resolves attacks between the two fighters and owns each player's health and shield values. It sits directly downstream of the per-player input and action logic. It consumes each player's one-cycle attack-request pulse, the shield-button level and the position stage's AABB collision flag. It drives the health/shield bars consumed by the VGA renderer, plus hit/block pulses and the end-of-round result.

## Interface
- `HEALTH_INIT`, 15: health loaded at reset (8-bit).
- `SHIELD_INIT`, 15: shield loaded at reset; also the regen ceiling.
- `ATTACK_DMG`, 2: health removed by an unblocked hit.
- `SHIELD_COST`, 3: shield removed by a blocked hit.
- `COOLDOWN_CYCLES`, 50_000_000: clk cycles after an accepted attack before that player may attack again (0.5 s at 100 MHz).
- `REGEN_PERIOD`, 100_000_000: clk cycles of shield released per +1 shield.
- `clk` input 1: system clock.
- `reset` input 1: reset, synchronous, active-low; clock `clk`.
- `p1_attack_req`, `p2_attack_req` input 1: single-cycle attack request pulses.
- `p1_shield_held`, `p2_shield_held` input 1: shield button level.
- `collision` input 1: fighters overlapping (from the position stage).
- `p1_health`, `p1_shield`, `p2_health`, `p2_shield` output 8: current values.
- `p1_hit`, `p2_hit` output 1: one-cycle pulse, that player took health damage.
- `p1_blocked`, `p2_blocked` output 1: one-cycle pulse, that player blocked a hit.
- `game_over` output 1: round finished; level held until reset.
- `winner` output 2: 00 none, 01 P1, 10 P2, 11 draw.

## Operation
**Reset (reset==0)**
- Health resets to `HEALTH_INIT` and shield to `SHIELD_INIT`.
- All pulses, `game_over` and `winner` reset to 0.
- Cooldown and regen counters clear.
- FSM enters FIGHT.

**FSM**
- FIGHT: on a cycle whose resolved next health is 0 for either player, go to OVER.
  - Only P2 at 0: `winner` = 01.
  - Only P1 at 0: `winner` = 10.
  - Both at 0 in the same cycle: `winner` = 11.
- OVER: absorbing until reset.
  - Attack requests are ignored, no pulses are produced and regen stops.
  - Health and shield values freeze.

**Attack acceptance (per attacker)**
- An attack is accepted when all hold: request pulse high, cooldown counter == 0, state == FIGHT.
- Accepting loads cooldown with `COOLDOWN_CYCLES`-1, then decrements once per cycle to 0.
- A request arriving while cooldown ≠ 0 is dropped; it is not queued.
- An accepted attack is loaded into cooldown whether or not it hits.

**Hit resolution (per defender)**
- A hit occurs when the opponent's attack is accepted and `collision`==1 in that same cycle.
- Block: if defender `shield_held`==1 and defender shield ≥ `SHIELD_COST`:
  - shield -= `SHIELD_COST`;
  - health unchanged;
  - `blocked` pulse.
- Otherwise: health = max(health - `ATTACK_DMG`, 0), and `hit` pulse.
  - A held shield with insufficient charge does not block and is not drained.
- Simultaneous accepted attacks from both players resolve independently in the same cycle (trade).

**Shield regen (per player)**
- Active when `shield_held`==0, shield < `SHIELD_INIT`, state FIGHT, and no block in this cycle.
- The regen counter counts to `REGEN_PERIOD`-1. On wrap, shield += 1, saturating at `SHIELD_INIT`.
- The counter clears whenever the player is not eligible (shield held, shield full, block this cycle, or state OVER).
- Arithmetic: compare before subtract; 8-bit values never wrap below 0 or above init.

## Timing
- All outputs are registered.
- Request pulse sampled at edge N gives updated health/shield, the `hit`/`blocked` pulse, and `game_over`/`winner` all valid after edge N+1. Latency is 1 cycle.
- Pulses are exactly one cycle wide.
- Cooldown: after acceptance at edge N, the next acceptance is possible no earlier than edge N+`COOLDOWN_CYCLES`.
- Reset asserted mid-round or mid-cooldown: at the next edge, every state element returns to its reset value.
- `collision` and `shield_held` are sampled only in the cycle of the accepted request.

## Structure
- Shared header `game_defs.vh` holds:
  - `HEALTH_INIT` and `SHIELD_INIT`;
  - the `winner` encodings `WIN_NONE`, `WIN_P1`, `WIN_P2`, `WIN_DRAW`;
  - the FSM state encodings `ST_FIGHT`, `ST_OVER`.
- Sub-module `fighter_stats`, instantiated twice, holds per player:
  - cooldown counter;
  - regen counter;
  - health and shield registers;
  - block/damage decision, given `incoming_hit` and `shield_held`.
- The top level holds the acceptance gating, the cross-wiring of attacker to defender, and the FSM/winner logic.
- Counter widths come from `$clog2` of the parameters.

## Test plan
Benches set `COOLDOWN_CYCLES`=8 and `REGEN_PERIOD`=16.
- P1 req, collision=1, P2 not shielding → `p2_health` 15→13 one cycle later; `p2_hit` high 1 cycle.
- P1 req, collision=1, P2 shield held, shield 15 → `p2_shield`=12, `p2_health`=15, `p2_blocked` pulse. With P2 shield at 2 instead → `p2_health` −2 and shield stays 2.
- P1 req at cycle 0 and again at cycle 5 → second dropped. Req at cycle 8 → accepted.
- After a block (P2 shield 12), release the shield for 48 cycles → shield 15. No further increment after that.
- Both health at 2, simultaneous accepted reqs with collision → both health 0, `game_over`=1, `winner`=11. Later reqs are ignored.
- P2 health driven to 0 → `winner`=01. Then reset low for one cycle → health 15/15, `game_over`=0, `winner`=00.

Source files
------------

// File: rtl/combat_resolver_pkg.sv
// Shared game definitions for the combat path: default stat values, winner codes
// and FSM state encodings used by the resolver and the VGA bar renderer.
package combat_resolver_pkg;

    localparam int unsigned HEALTH_INIT = 15;
    localparam int unsigned SHIELD_INIT = 15;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    typedef enum logic {
        ST_FIGHT = 1'b0,
        ST_OVER  = 1'b1
    } state_e;

    // Compare before subtract so 8-bit stats never wrap below zero.
    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : 8'd0;
    endfunction

endpackage

// File: rtl/fighter_stats.sv
// Per-player state: attack cooldown, shield regen timer, health/shield registers
// and the block-versus-damage decision for an incoming hit.
module fighter_stats
    import combat_resolver_pkg::*;
#(
    parameter int unsigned HEALTH_INIT     = combat_resolver_pkg::HEALTH_INIT,
    parameter int unsigned SHIELD_INIT     = combat_resolver_pkg::SHIELD_INIT,
    parameter int unsigned ATTACK_DMG      = 2,
    parameter int unsigned SHIELD_COST     = 3,
    parameter int unsigned COOLDOWN_CYCLES = 50_000_000,
    parameter int unsigned REGEN_PERIOD    = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       active,
    input  logic       attack_accepted,
    input  logic       incoming_hit,
    input  logic       shield_held,
    output logic       cooldown_idle,
    output logic [7:0] health_next,
    output logic [7:0] health,
    output logic [7:0] shield,
    output logic       hit,
    output logic       blocked
);

    localparam int unsigned CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int unsigned RG_W = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [RG_W-1:0] RG_LAST = RG_W'(REGEN_PERIOD - 1);
    localparam logic [7:0] H_INIT = 8'(HEALTH_INIT);
    localparam logic [7:0] S_INIT = 8'(SHIELD_INIT);
    localparam logic [7:0] DMG    = 8'(ATTACK_DMG);
    localparam logic [7:0] COST   = 8'(SHIELD_COST);

    logic [CD_W-1:0] cd_q, cd_d;
    logic [RG_W-1:0] regen_q, regen_d;
    logic [7:0]      health_q, shield_q, shield_d;
    logic            hit_q, blocked_q;
    logic            block, damage, regen_en, regen_wrap;

    always_comb begin
        // An under-charged shield neither blocks nor drains.
        block       = incoming_hit && shield_held && (shield_q >= COST);
        damage      = incoming_hit && !block;
        health_next = damage ? sat_sub(health_q, DMG) : health_q;

        regen_en   = !shield_held && (shield_q < S_INIT) && active && !block;
        regen_wrap = regen_en && (regen_q == RG_LAST);
        regen_d    = (regen_en && !regen_wrap) ? regen_q + 1'b1 : '0;

        shield_d = shield_q;
        if (block) begin
            shield_d = shield_q - COST;
        end else if (regen_wrap) begin
            shield_d = shield_q + 8'd1;
        end

        cd_d = cd_q;
        if (attack_accepted) begin
            cd_d = CD_LOAD;
        end else if (cd_q != '0) begin
            cd_d = cd_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cd_q      <= '0;
            regen_q   <= '0;
            health_q  <= H_INIT;
            shield_q  <= S_INIT;
            hit_q     <= 1'b0;
            blocked_q <= 1'b0;
        end else begin
            cd_q      <= cd_d;
            regen_q   <= regen_d;
            health_q  <= health_next;
            shield_q  <= shield_d;
            hit_q     <= damage;
            blocked_q <= block;
        end
    end

    assign cooldown_idle = (cd_q == '0);
    assign health        = health_q;
    assign shield        = shield_q;
    assign hit           = hit_q;
    assign blocked       = blocked_q;

endmodule

// File: rtl/combat_resolver.sv
// Two-player combat resolver: gates attack requests, routes each accepted attack
// to the opposing fighter and tracks the round result.
module combat_resolver
    import combat_resolver_pkg::*;
#(
    parameter int unsigned HEALTH_INIT     = combat_resolver_pkg::HEALTH_INIT,
    parameter int unsigned SHIELD_INIT     = combat_resolver_pkg::SHIELD_INIT,
    parameter int unsigned ATTACK_DMG      = 2,
    parameter int unsigned SHIELD_COST     = 3,
    parameter int unsigned COOLDOWN_CYCLES = 50_000_000,
    parameter int unsigned REGEN_PERIOD    = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1_attack_req,
    input  logic       p2_attack_req,
    input  logic       p1_shield_held,
    input  logic       p2_shield_held,
    input  logic       collision,
    output logic [7:0] p1_health,
    output logic [7:0] p1_shield,
    output logic [7:0] p2_health,
    output logic [7:0] p2_shield,
    output logic       p1_hit,
    output logic       p2_hit,
    output logic       p1_blocked,
    output logic       p2_blocked,
    output logic       game_over,
    output logic [1:0] winner
);

    state_e     state_q, state_d;
    logic [1:0] winner_q, winner_d;
    logic       game_over_q;
    logic       fight;
    logic       p1_cd_idle, p2_cd_idle;
    logic       p1_accept, p2_accept;
    logic [7:0] p1_health_next, p2_health_next;
    logic       p1_dead, p2_dead;

    assign fight     = (state_q == ST_FIGHT);
    assign p1_accept = p1_attack_req && p1_cd_idle && fight;
    assign p2_accept = p2_attack_req && p2_cd_idle && fight;

    fighter_stats #(
        .HEALTH_INIT    (HEALTH_INIT),
        .SHIELD_INIT    (SHIELD_INIT),
        .ATTACK_DMG     (ATTACK_DMG),
        .SHIELD_COST    (SHIELD_COST),
        .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
        .REGEN_PERIOD   (REGEN_PERIOD)
    ) u_p1 (
        .clk            (clk),
        .reset          (reset),
        .active         (fight),
        .attack_accepted(p1_accept),
        .incoming_hit   (p2_accept && collision),
        .shield_held    (p1_shield_held),
        .cooldown_idle  (p1_cd_idle),
        .health_next    (p1_health_next),
        .health         (p1_health),
        .shield         (p1_shield),
        .hit            (p1_hit),
        .blocked        (p1_blocked)
    );

    fighter_stats #(
        .HEALTH_INIT    (HEALTH_INIT),
        .SHIELD_INIT    (SHIELD_INIT),
        .ATTACK_DMG     (ATTACK_DMG),
        .SHIELD_COST    (SHIELD_COST),
        .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
        .REGEN_PERIOD   (REGEN_PERIOD)
    ) u_p2 (
        .clk            (clk),
        .reset          (reset),
        .active         (fight),
        .attack_accepted(p2_accept),
        .incoming_hit   (p1_accept && collision),
        .shield_held    (p2_shield_held),
        .cooldown_idle  (p2_cd_idle),
        .health_next    (p2_health_next),
        .health         (p2_health),
        .shield         (p2_shield),
        .hit            (p2_hit),
        .blocked        (p2_blocked)
    );

    assign p1_dead = (p1_health_next == 8'd0);
    assign p2_dead = (p2_health_next == 8'd0);

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        unique case (state_q)
            ST_FIGHT: begin
                if (p1_dead || p2_dead) begin
                    state_d = ST_OVER;
                    if (p1_dead && p2_dead) begin
                        winner_d = WIN_DRAW;
                    end else if (p2_dead) begin
                        winner_d = WIN_P1;
                    end else begin
                        winner_d = WIN_P2;
                    end
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_FIGHT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_FIGHT;
            winner_q    <= WIN_NONE;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            game_over_q <= (state_d == ST_OVER);
        end
    end

    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Directed bench for combat_resolver with short cooldown/regen periods.
module tb_combat_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic       p1_attack_req, p2_attack_req;
    logic       p1_shield_held, p2_shield_held;
    logic       collision;
    logic [7:0] p1_health, p1_shield, p2_health, p2_shield;
    logic       p1_hit, p2_hit, p1_blocked, p2_blocked;
    logic       game_over;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    combat_resolver #(
        .COOLDOWN_CYCLES(8),
        .REGEN_PERIOD   (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .p1_attack_req (p1_attack_req),
        .p2_attack_req (p2_attack_req),
        .p1_shield_held(p1_shield_held),
        .p2_shield_held(p2_shield_held),
        .collision     (collision),
        .p1_health     (p1_health),
        .p1_shield     (p1_shield),
        .p2_health     (p2_health),
        .p2_shield     (p2_shield),
        .p1_hit        (p1_hit),
        .p2_hit        (p2_hit),
        .p1_blocked    (p1_blocked),
        .p2_blocked    (p2_blocked),
        .game_over     (game_over),
        .winner        (winner)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One edge with the chosen requests and collision, then requests drop.
    task automatic attack(input logic r1, input logic r2);
        p1_attack_req = r1;
        p2_attack_req = r2;
        collision     = 1'b1;
        tick();
        p1_attack_req = 1'b0;
        p2_attack_req = 1'b0;
        collision     = 1'b0;
    endtask

    task automatic wait_cd();
        repeat (8) tick();
    endtask

    task automatic check_fresh(input string tag);
        check({tag, "_p1h"}, int'(p1_health), 15);
        check({tag, "_p2h"}, int'(p2_health), 15);
        check({tag, "_p1s"}, int'(p1_shield), 15);
        check({tag, "_p2s"}, int'(p2_shield), 15);
        check({tag, "_go"}, int'(game_over), 0);
        check({tag, "_win"}, int'(winner), 0);
    endtask

    initial begin
        reset          = 1'b0;
        p1_attack_req  = 1'b0;
        p2_attack_req  = 1'b0;
        p1_shield_held = 1'b0;
        p2_shield_held = 1'b0;
        collision      = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        check_fresh("rst");
        check("rst_pulses", int'({p1_hit, p2_hit, p1_blocked, p2_blocked}), 0);

        // Plain hit, then cooldown drop at cycle 5 and acceptance at cycle 8.
        attack(1'b1, 1'b0);
        check("hit_p2h", int'(p2_health), 13);
        check("hit_p2pulse", int'(p2_hit), 1);
        check("hit_p1h", int'(p1_health), 15);
        tick();
        check("hit_pulse_end", int'(p2_hit), 0);
        repeat (3) tick();
        attack(1'b1, 1'b0);
        check("cd_drop_p2h", int'(p2_health), 13);
        check("cd_drop_pulse", int'(p2_hit), 0);
        repeat (2) tick();
        attack(1'b1, 1'b0);
        check("cd_accept_p2h", int'(p2_health), 11);
        check("cd_accept_pulse", int'(p2_hit), 1);

        // Block with full shield.
        wait_cd();
        p2_shield_held = 1'b1;
        attack(1'b1, 1'b0);
        check("blk_p2s", int'(p2_shield), 12);
        check("blk_p2h", int'(p2_health), 11);
        check("blk_pulse", int'(p2_blocked), 1);
        check("blk_nohit", int'(p2_hit), 0);
        tick();
        check("blk_pulse_end", int'(p2_blocked), 0);

        // Regen 12 -> 15 over 48 cycles, then saturate.
        p2_shield_held = 1'b0;
        repeat (47) tick();
        check("regen_47", int'(p2_shield), 14);
        tick();
        check("regen_48", int'(p2_shield), 15);
        repeat (20) tick();
        check("regen_sat", int'(p2_shield), 15);

        // Drain shield 15 -> 0 by five blocks, regen to 2, then weak shield fails.
        p2_shield_held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_cd();
            attack(1'b1, 1'b0);
        end
        check("drain_p2s", int'(p2_shield), 0);
        check("drain_p2h", int'(p2_health), 11);
        p2_shield_held = 1'b0;
        repeat (32) tick();
        check("regen_to2", int'(p2_shield), 2);
        p2_shield_held = 1'b1;
        attack(1'b1, 1'b0);
        check("weak_p2h", int'(p2_health), 9);
        check("weak_p2s", int'(p2_shield), 2);
        check("weak_hit", int'(p2_hit), 1);
        check("weak_noblk", int'(p2_blocked), 0);
        p2_shield_held = 1'b0;

        // Trades down to P1=7/P2=1, P2 alone takes P1 to 1, then a draw.
        for (int k = 1; k <= 4; k++) begin
            wait_cd();
            attack(1'b1, 1'b1);
            check("trade_p1h", int'(p1_health), 15 - 2 * k);
            check("trade_p2h", int'(p2_health), 9 - 2 * k);
        end
        check("trade_hits", int'({p1_hit, p2_hit}), 3);
        for (int j = 1; j <= 3; j++) begin
            wait_cd();
            attack(1'b0, 1'b1);
            check("p2only_p1h", int'(p1_health), 7 - 2 * j);
        end
        check("pre_draw_go", int'(game_over), 0);
        wait_cd();
        attack(1'b1, 1'b1);
        check("draw_p1h", int'(p1_health), 0);
        check("draw_p2h", int'(p2_health), 0);
        check("draw_go", int'(game_over), 1);
        check("draw_win", int'(winner), 3);
        check("draw_hits", int'({p1_hit, p2_hit}), 3);
        tick();
        check("draw_pulse_end", int'({p1_hit, p2_hit}), 0);
        wait_cd();
        attack(1'b1, 1'b1);
        check("over_hits", int'({p1_hit, p2_hit, p1_blocked, p2_blocked}), 0);
        check("over_p1h", int'(p1_health), 0);
        check("over_p1s", int'(p1_shield), 15);
        check("over_go", int'(game_over), 1);
        check("over_win", int'(winner), 3);

        // Fresh round: P1 wins by eight hits.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_fresh("rst2");
        for (int n = 1; n <= 8; n++) begin
            if (n > 1) wait_cd();
            attack(1'b1, 1'b0);
            check("p1win_p2h", int'(p2_health), (n < 8) ? 15 - 2 * n : 0);
            check("p1win_go", int'(game_over), (n < 8) ? 0 : 1);
        end
        check("p1win_win", int'(winner), 1);
        check("p1win_p1h", int'(p1_health), 15);

        // Reset with P1 cooldown freshly loaded; the next request is accepted at once.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_fresh("rst3");
        attack(1'b1, 1'b0);
        check("post_rst_p2h", int'(p2_health), 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
